// File: rtl/crypto_sched_pkg.sv
// Shared definitions for the crypto job scheduler: op codes, FSM state
// encoding and default widths. The watchdog option is CRYPTO_SCHED_WDOG_EN.
package crypto_sched_pkg;

  localparam int DEFAULT_DATA_W      = 128;
  localparam int DEFAULT_TIMEOUT_CYC = 4096;

  localparam logic [1:0] OP_AES_ENC = 2'b00;
  localparam logic [1:0] OP_AES_DEC = 2'b01;
  localparam logic [1:0] OP_RSA_ENC = 2'b10;
  localparam logic [1:0] OP_RSA_DEC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/crypto_rr_arbiter.sv
// Two-way round-robin arbiter. ptr names the requester preferred when both
// request; a lone requester always wins. Output is one-hot or zero.
module crypto_rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Tie broken by ptr; otherwise the request vector is already one-hot or zero.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/crypto_job_scheduler.sv
// Two-requester job scheduler for the shared crypto engine bank.
// Arbitrates jobs, sequences the engine hold/run protocol and returns the
// result on a valid/ready response port.
// Optional watchdog: define CRYPTO_SCHED_WDOG_EN to enable the RUN timeout.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. req_valid[i] is held by the source until it sees
// req_ready[i]; rsp_valid stays high with stable rsp_* fields until rsp_ready.
module crypto_job_scheduler
  import crypto_sched_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                Master_clk,
  input  logic                Master_reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [3:0]          req_op,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          eng_sel,
  output logic                eng_reset,
  output logic [DATA_W-1:0]   eng_operand,
  input  logic                eng_done,
  input  logic [DATA_W-1:0]   eng_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_id,
  output logic [1:0]          rsp_op,
  output logic                rsp_err,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  state_t     state;
  logic       rr_ptr;
  logic       job_id;
  logic [1:0] grant;
  logic       accept;
  logic       gidx;

  crypto_rr_arbiter u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grants are only offered while idle so at most one job is ever in flight.
  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gidx      = grant[1];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef CRYPTO_SCHED_WDOG_EN
  logic [31:0] wdog_cnt;
  logic        rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign rsp_err        = 1'b0;
`endif

  // Job FSM: latch job, hold engine one cycle, run until done, present response.
  always_ff @(posedge Master_clk or negedge Master_reset) begin
    if (!Master_reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      job_id      <= 1'b0;
      eng_sel     <= 2'b00;
      eng_reset   <= 1'b1;
      eng_operand <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= 1'b0;
      rsp_op      <= 2'b00;
`ifdef CRYPTO_SCHED_WDOG_EN
      wdog_cnt    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            job_id      <= gidx;
            eng_sel     <= gidx ? req_op[3:2] : req_op[1:0];
            eng_operand <= gidx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
            rr_ptr      <= ~gidx;
            state       <= ST_START;
          end
        end
        // One cycle with the engine held clears any stale done flag.
        ST_START: begin
          eng_reset <= 1'b0;
          state     <= ST_RUN;
`ifdef CRYPTO_SCHED_WDOG_EN
          wdog_cnt  <= '0;
`endif
        end
        ST_RUN: begin
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_id    <= job_id;
            rsp_op    <= eng_sel;
            rsp_valid <= 1'b1;
            eng_reset <= 1'b1;
            state     <= ST_RESP;
`ifdef CRYPTO_SCHED_WDOG_EN
            rsp_err_q <= 1'b0;
          end else if (wdog_cnt == 32'(TIMEOUT_CYC - 1)) begin
            rsp_data  <= '0;
            rsp_id    <= job_id;
            rsp_op    <= eng_sel;
            rsp_err_q <= 1'b1;
            rsp_valid <= 1'b1;
            eng_reset <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wdog_cnt  <= wdog_cnt + 32'd1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
